// File: rtl/eeg_feat_pkg.sv
`default_nettype none
// ============================================================================
// Module  : eeg_feat_pkg
// Purpose : Shared defaults and helpers for the EEG feature-extraction blocks
//           (band_power and its siblings).
// Contents: DATA_W_DEF  - default filter-output sample width
//           OUT_W_DEF   - default feature output width
//           sat_trunc() - clamp an unsigned value to the largest w-bit value
// Revision: 1.0 - initial release
// ============================================================================
package eeg_feat_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OUT_W_DEF  = 32;

  // Widest value sat_trunc can handle; feature accumulators stay below this.
  localparam int SAT_MAX_W  = 128;

  // Returns min(v, 2^w - 1). The caller narrows the result to w bits; the
  // wide return type lets one function serve every output width.
  function automatic logic [SAT_MAX_W-1:0] sat_trunc(
    input logic [SAT_MAX_W-1:0] v,
    input int unsigned          w
  );
    logic [SAT_MAX_W-1:0] lim;
    if (w >= SAT_MAX_W) lim = '1;
    else                lim = (SAT_MAX_W'(1) << w) - SAT_MAX_W'(1);
    return (v > lim) ? lim : v;
  endfunction

endpackage : eeg_feat_pkg
`default_nettype wire

// File: rtl/band_power_sq_term.sv
`default_nettype none
// ============================================================================
// Module  : sq_term
// Purpose : Front two pipeline stages of band_power: magnitude capture and
//           scaled square, with a matching valid pipe.
// Ports   : clk      - clock, rising edge
//           reset    - asynchronous reset, active low
//           clear    - synchronous flush of the valid pipe
//           in_valid - x carries a sample
//           x        - signed sample
//           term_valid - term carries a squared sample
//           term     - (|x|*|x|) >> SQ_SHIFT, unsigned
// Revision: 1.0 - initial release
// ============================================================================
module sq_term #(
  parameter int DATA_W   = 32,
  parameter int SQ_SHIFT = 24,
  parameter int TERM_W   = 2*DATA_W - SQ_SHIFT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] x,
  output logic                     term_valid,
  output logic [TERM_W-1:0]        term
);

  logic [DATA_W-1:0]   w_abs;
  logic [2*DATA_W-1:0] w_mag_ext;
  logic [2*DATA_W-1:0] w_sq;

  logic                r_v1;
  logic [DATA_W-1:0]   r_mag;
  logic                r_v2;
  logic [TERM_W-1:0]   r_term;

  // Negating the most negative input wraps to 100..0, which read as unsigned
  // is exactly 2^(DATA_W-1), so no extra bit is needed for the magnitude.
  assign w_abs     = x[DATA_W-1] ? $unsigned(-x) : $unsigned(x);
  assign w_mag_ext = {{DATA_W{1'b0}}, r_mag};
  assign w_sq      = w_mag_ext * w_mag_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1   <= 1'b0;
      r_mag  <= '0;
      r_v2   <= 1'b0;
      r_term <= '0;
    end else begin
      // clear drops both the incoming sample and anything already in flight
      r_v1 <= in_valid & ~clear;
      r_v2 <= r_v1 & ~clear;
      if (in_valid) r_mag  <= w_abs;
      if (r_v1)     r_term <= TERM_W'(w_sq >> SQ_SHIFT);
    end
  end

  assign term_valid = r_v2;
  assign term       = r_term;

endmodule : sq_term
`default_nettype wire

// File: rtl/band_power.sv
`default_nettype none
// ============================================================================
// Module  : band_power
// Purpose : Windowed mean-power estimator. Squares each accepted sample,
//           sums 2^WIN_LOG2 of them and emits the saturated mean with a
//           one-cycle strobe and a threshold-compare flag.
// Ports   : clk       - clock, rising edge
//           reset     - asynchronous reset, active low
//           clear     - synchronous window restart (drops in-flight samples)
//           in_valid  - x carries a sample
//           x         - signed filter output sample
//           thr       - unsigned detection threshold
//           power     - mean power of the last completed window
//           out_valid - one-cycle pulse when power/above update
//           above     - power > thr, sampled when power updates
// Revision: 1.0 - initial release
// ============================================================================
module band_power
  import eeg_feat_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WIN_LOG2 = 8,
  parameter int SQ_SHIFT = 24,
  parameter int OUT_W    = OUT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] x,
  input  logic [OUT_W-1:0]         thr,
  output logic [OUT_W-1:0]         power,
  output logic                     out_valid,
  output logic                     above
);

  localparam int TERM_W = 2*DATA_W - SQ_SHIFT;
  // Sized for 2^WIN_LOG2 full-scale terms, so the sum never wraps.
  localparam int ACC_W  = TERM_W + WIN_LOG2;

  logic                w_term_valid;
  logic [TERM_W-1:0]   w_term;
  logic [ACC_W-1:0]    w_sum;
  logic [OUT_W-1:0]    w_pow;
  logic                w_last;

  logic [ACC_W-1:0]    r_acc;
  logic [WIN_LOG2-1:0] r_cnt;

  sq_term #(
    .DATA_W   (DATA_W),
    .SQ_SHIFT (SQ_SHIFT),
    .TERM_W   (TERM_W)
  ) u_sq_term (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .x          (x),
    .term_valid (w_term_valid),
    .term       (w_term)
  );

  assign w_sum  = r_acc + ACC_W'(w_term);
  assign w_pow  = OUT_W'(sat_trunc(SAT_MAX_W'(w_sum >> WIN_LOG2), OUT_W));
  // All-ones count means this term closes the window.
  assign w_last = &r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      power     <= '0;
      above     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        // power/above deliberately hold their last window's result
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_term_valid) begin
        r_cnt <= r_cnt + 1'b1;  // wraps to 0 exactly at the window end
        if (w_last) begin
          r_acc     <= '0;
          power     <= w_pow;
          above     <= (w_pow > thr);
          out_valid <= 1'b1;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

endmodule : band_power
`default_nettype wire

// File: tb/tb_band_power.sv
`default_nettype none
// ============================================================================
// Module  : tb_band_power
// Purpose : Self-checking bench for band_power. Three instances share one
//           stimulus stream: (SQ_SHIFT=0,OUT_W=32), (SQ_SHIFT=32,OUT_W=32)
//           and (SQ_SHIFT=0,OUT_W=16), all with WIN_LOG2=2.
// Revision: 1.0 - initial release
// ============================================================================
module tb_band_power;

  typedef struct {
    int          edge_no;
    logic [31:0] pwr;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               clear;
  logic               in_valid;
  logic signed [31:0] x;
  logic [31:0]        thr;

  logic [31:0] power_a, power_b;
  logic [15:0] power_c;
  logic        ov_a, ov_b, ov_c;
  logic        ab_a, ab_b, ab_c;

  int          shift_of [3] = '{0, 32, 0};
  int          width_of [3] = '{32, 32, 16};

  exp_t        sb [3][$];
  logic [31:0] thr_at [int];
  logic [127:0] win [$];
  logic [31:0] last_p [3];
  logic        last_a [3];
  int          edge_n = 0;
  int          total  = 0;
  int          bad    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  band_power #(.DATA_W(32), .WIN_LOG2(2), .SQ_SHIFT(0),  .OUT_W(32)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .x(x),
    .thr(thr), .power(power_a), .out_valid(ov_a), .above(ab_a));
  band_power #(.DATA_W(32), .WIN_LOG2(2), .SQ_SHIFT(32), .OUT_W(32)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .x(x),
    .thr(thr), .power(power_b), .out_valid(ov_b), .above(ab_b));
  band_power #(.DATA_W(32), .WIN_LOG2(2), .SQ_SHIFT(0),  .OUT_W(16)) dut_c (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .x(x),
    .thr(thr[15:0]), .power(power_c), .out_valid(ov_c), .above(ab_c));

  // Reference model: collect accepted magnitudes; once a window is full,
  // compute mean of shifted squares, clamp, and schedule the result two
  // edges after the accepting edge.
  task automatic push_sample(input logic signed [31:0] xv);
    logic [127:0] m, sum, lim, p;
    m = 128'(xv < 0 ? -longint'(xv) : longint'(xv));
    win.push_back(m);
    if (win.size() == 4) begin
      for (int d = 0; d < 3; d++) begin
        sum = '0;
        foreach (win[j]) sum += (win[j] * win[j]) >> shift_of[d];
        lim = (128'd1 << width_of[d]) - 128'd1;
        p   = (sum >> 2) > lim ? lim : (sum >> 2);
        sb[d].push_back('{edge_n + 3, 32'(p)});
      end
      win.delete();
    end
  endtask

  task automatic drive(input logic v, input logic signed [31:0] xv,
                       input logic clr, input logic [31:0] t);
    @(posedge clk); #1;
    in_valid = v; x = xv; clear = clr; thr = t;
    thr_at[edge_n + 1] = t;
    if (clr) begin
      // the partial window and anything not yet accumulated are lost
      win.delete();
      for (int d = 0; d < 3; d++)
        while (sb[d].size() > 0 && sb[d][$].edge_no >= edge_n + 1)
          void'(sb[d].pop_back());
    end else if (v) begin
      push_sample(xv);
    end
  endtask

  task automatic idle(input int n, input logic [31:0] t);
    repeat (n) drive(1'b0, 32'sd0, 1'b0, t);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b1; x = 32'sd100; clear = 1'b0;
    win.delete();
    for (int d = 0; d < 3; d++) begin
      sb[d].delete(); last_p[d] = '0; last_a[d] = 1'b0;
    end
    repeat (n) @(posedge clk);
    #1 reset = 1'b1; in_valid = 1'b0;
  endtask

  task automatic check(input int d, input logic [31:0] p, input logic v,
                       input logic a);
    exp_t        e;
    logic        ea;
    logic [31:0] mask;
    logic        missed;
    mask = (width_of[d] == 16) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    total++;
    if (!reset) begin
      if (p !== '0 || v !== 1'b0 || a !== 1'b0) begin
        bad++;
        $display("FAIL reset_out dut%0d: power=%0d out_valid=%b above=%b, required 0 0 0",
                 d, p, v, a);
      end
    end else if (v === 1'b1) begin
      if (sb[d].size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse dut%0d edge %0d: power=%0d, required no pulse",
                 d, edge_n, p);
      end else begin
        e  = sb[d].pop_front();
        ea = e.pwr > (thr_at[e.edge_no] & mask);
        if (e.edge_no != edge_n || p !== e.pwr || a !== ea) begin
          bad++;
          $display("FAIL window dut%0d: edge=%0d power=%0d above=%b, required edge=%0d power=%0d above=%b",
                   d, edge_n, p, a, e.edge_no, e.pwr, ea);
        end
        last_p[d] = e.pwr;
        last_a[d] = ea;
      end
    end else begin
      missed = 1'b0;
      if (sb[d].size() > 0 && sb[d][0].edge_no <= edge_n) begin
        missed = 1'b1;
        e = sb[d].pop_front();
        last_p[d] = e.pwr;
        last_a[d] = e.pwr > (thr_at[e.edge_no] & mask);
      end
      if (missed || p !== last_p[d] || a !== last_a[d]) begin
        bad++;
        $display("FAIL hold dut%0d edge %0d: power=%0d above=%b pulse_missed=%b, required power=%0d above=%b pulse_missed=0",
                 d, edge_n, p, a, missed, last_p[d], last_a[d]);
      end
    end
  endtask

  // Monitor: runs on the falling edge, independent of the stimulus process.
  always @(negedge clk) begin
    check(0, power_a, ov_a, ab_a);
    check(1, power_b, ov_b, ab_b);
    check(2, {16'h0, power_c}, ov_c, ab_c);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    logic        v, c;
    logic [31:0] t;
    logic signed [31:0] xv;
    for (int d = 0; d < 3; d++) begin last_p[d] = '0; last_a[d] = 1'b0; end
    reset = 1'b0; clear = 1'b0; in_valid = 1'b1; x = 32'sd100; thr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1; in_valid = 1'b0;

    // first window after reset
    repeat (4) drive(1'b1, 32'sd100, 1'b0, 32'd0);
    idle(3, 32'd0);
    // strict threshold compare
    repeat (4) drive(1'b1, 32'sd100, 1'b0, 32'd9999);
    idle(3, 32'd9999);
    repeat (4) drive(1'b1, 32'sd100, 1'b0, 32'd10000);
    idle(3, 32'd10000);
    // signs and gaps
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i % 2 == 0) ? -32'sd3 : 32'sd3, 1'b0, 32'd5);
      idle(2, 32'd5);
    end
    // most negative input
    repeat (4) drive(1'b1, 32'h8000_0000, 1'b0, 32'd7);
    idle(3, 32'd7);
    // saturation on the 16-bit instance
    repeat (4) drive(1'b1, 32'sd1000, 1'b0, 32'd50000);
    idle(3, 32'd50000);
    // clear mid-window: dropped sample, fresh window
    repeat (2) drive(1'b1, 32'sd100, 1'b0, 32'd1);
    drive(1'b1, 32'sd100, 1'b1, 32'd1);
    repeat (4) drive(1'b1, 32'sd10, 1'b0, 32'd99);
    idle(3, 32'd99);
    // reset mid-window
    repeat (3) drive(1'b1, 32'sd100, 1'b0, 32'd0);
    do_reset(2);
    idle(3, 32'd0);
    // streaming 1..12
    for (int i = 1; i <= 12; i++) drive(1'b1, 32'(i), 1'b0, 32'd43);
    idle(3, 32'd43);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        v  = ($urandom_range(0, 3) != 0);
        c  = ($urandom_range(0, 39) == 0);
        xv = ($urandom_range(0, 2) == 0) ? $signed($urandom)
                                         : $signed($urandom_range(0, 2000)) - 32'sd1000;
        t  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 300000) : $urandom;
        drive(v, xv, c, t);
      end
    end
    idle(5, 32'd0);

    for (int d = 0; d < 3; d++) begin
      total++;
      if (sb[d].size() != 0) begin
        bad++;
        $display("FAIL drain dut%0d: pending=%0d, required 0", d, sb[d].size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_band_power
`default_nettype wire
